// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
//
// Owns the program counter, issues in-order word requests to instruction memory, buffers
// returned words in a small FIFO and registers the IF/ID outputs. A credit rule
// (buffered words + outstanding requests < BUF_DEPTH) guarantees that every response
// has a free buffer slot. A redirect flushes the buffer and marks all outstanding
// responses for discard so that stale words never reach decode.
//
// Optional feature (macro FETCH_STAT_EN): adds bubble_count_o, a wrapping counter of
// cycles in which decode could accept but no instruction was available.
//
// Ports:
//   clk_i           clock, all state updates on posedge
//   rst_i           synchronous, active-high reset
//   imem_req_o      request valid to instruction memory
//   imem_addr_o     word-aligned request address
//   imem_ready_i    memory accepts the request this cycle
//   imem_rvalid_i   response valid (one per accepted request, in order)
//   imem_rdata_i    response instruction word
//   stall_i         decode cannot accept; hold IF/ID outputs
//   redirect_i      taken branch/jump; flush and refetch
//   redirect_pc_i   new fetch address, bits [1:0] ignored
//   instr_o         instruction to decode
//   pc_out_o        address of instr_o
//   next_pc_out_o   pc_out_o + 4
//   instr_valid_o   instr_o/pc_out_o hold a real instruction
//   bubble_count_o  (FETCH_STAT_EN only) empty-output cycle counter

module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_out_o,
    output logic [31:0] next_pc_out_o,
    output logic        instr_valid_o
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] bubble_count_o
`endif
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;       // pc of the next kept response
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]     buf_instr_q [BUF_DEPTH];
    logic [31:0]     buf_pc_q    [BUF_DEPTH];

    logic [31:0]     instr_q, instr_d;
    logic [31:0]     pc_out_q, pc_out_d;
    logic [31:0]     next_pc_q, next_pc_d;
    logic            valid_q, valid_d;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [CntW:0]   credit_sum;
    logic            accept;
    logic            rsp_keep;
    logic            pop_en;
    logic            buf_empty;
    logic            pop_buf;
    logic            bypass;
    logic            push_buf;
    logic [31:0]     redirect_pc_aligned;
    logic            unused_pc_bits;

    assign unused_pc_bits      = ^redirect_pc_i[1:0];
    assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};

    assign credit_sum  = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_o  = !rst_i && !redirect_i && (credit_sum < (CntW + 1)'(BUF_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign accept      = imem_req_o && imem_ready_i;

    // A response arriving during a redirect is counted as consumed but never used.
    assign rsp_keep  = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign pop_en    = !stall_i && !redirect_i;
    assign buf_empty = (count_q == '0);
    assign pop_buf   = pop_en && !buf_empty;
    // An arriving word goes straight to the output only when nothing older is buffered.
    assign bypass    = pop_en && buf_empty && rsp_keep;
    assign push_buf  = rsp_keep && !bypass;

    // ------------------------------------------------------------------
    // Next-state logic: fetch side
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CntW'(accept) - CntW'(imem_rvalid_i);
        discard_d     = discard_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - CntW'(imem_rvalid_i);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - CntW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: buffer pointers
    // ------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (redirect_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CntW'(push_buf) - CntW'(pop_buf);
            if (push_buf) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_buf) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: IF/ID output register
    // ------------------------------------------------------------------
    always_comb begin
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        next_pc_d = next_pc_q;
        valid_d   = valid_q;

        if (redirect_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            // hold
        end else if (pop_buf) begin
            instr_d   = buf_instr_q[rd_ptr_q];
            pc_out_d  = buf_pc_q[rd_ptr_q];
            next_pc_d = buf_pc_q[rd_ptr_q] + 32'd4;
            valid_d   = 1'b1;
        end else if (bypass) begin
            instr_d   = imem_rdata_i;
            pc_out_d  = rsp_pc_q;
            next_pc_d = rsp_pc_q + 32'd4;
            valid_d   = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_q       <= NOP_INSTR;
            pc_out_q      <= '0;
            next_pc_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            next_pc_q     <= next_pc_d;
            valid_q       <= valid_d;
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_buf) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata_i;
            buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_buf && !pop_buf && (count_q == CntW'(BUF_DEPTH))))
                else $error("instr_fetch: push into full fetch buffer");
        end
    end
`endif

    assign instr_o       = instr_q;
    assign pc_out_o      = pc_out_q;
    assign next_pc_out_o = next_pc_q;
    assign instr_valid_o = valid_q;

`ifdef FETCH_STAT_EN
    // ------------------------------------------------------------------
    // Bubble statistics
    // ------------------------------------------------------------------
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (pop_en && !pop_buf && !bypass) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_count_o = bubble_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. A small memory model answers every accepted
// request after a programmable latency with data = ~address, so each word identifies
// the pc it came from. Outputs are sampled 1 time unit after the rising edge.
// Define FETCH_STAT_EN to also check bubble_count_o.

module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic        instr_valid;
`ifdef FETCH_STAT_EN
    logic [31:0] bubble_count;
`endif

    localparam logic [31:0] Nop = 32'h0000_0013;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .pc_out_o      (pc_out),
        .next_pc_out_o (next_pc_out),
        .instr_valid_o (instr_valid)
`ifdef FETCH_STAT_EN
        ,
        .bubble_count_o(bubble_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: record an acceptance before the edge, then drive the response for
    // the following cycle.
    task automatic tick();
        @(negedge clk);
        if (imem_req && imem_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_npc"}, next_pc_out, pc + 32'd4);
        check({tag, "_instr"}, instr, ~pc);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr, Nop);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        tick();
        tick();
        check_empty("rst");
        check("rst_pc", pc_out, 32'h0);
        check("rst_npc", next_pc_out, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_STAT_EN
        check("rst_bubble", bubble_count, 32'd0);
`endif

        // Streaming, 1-cycle memory latency.
        rst = 1'b0;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check_empty("first_gap");
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("stream", 32'(4 * i));
        end

        // Stall 3 cycles while memory keeps answering.
        stall = 1'b1;
        tick();
        check_out("stall1", 32'd12);
        tick();
        check("stall_req", {31'b0, imem_req}, 32'd0);
        tick();
        check_out("stall3", 32'd12);
        stall = 1'b0;
        tick();
        check_out("rel16", 32'd16);
        tick();
        check_out("rel20", 32'd20);
        tick();
        check_out("rel24", 32'd24);

        // Two requests in flight, then redirect to an unaligned target.
        lat = 2;
        tick();
        check_out("pre28", 32'd28);
        tick();
        check_empty("lat_gap");
        check("lat_gap_pc", pc_out, 32'd28);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("redir_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check_empty("redir1");
        check("redir_addr", imem_addr, 32'h0000_0100);
        tick();
        check_empty("redir2");
        tick();
        check_empty("redir3");
        tick();
        check_out("redir_tgt", 32'h0000_0100);

        // Redirect and stall together: redirect wins, the arriving word is dropped.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        check_empty("rs1");
        tick();
        tick();
        check_empty("rs3");
        tick();
        check_out("rs_tgt", 32'h0000_0200);

        // Address wrap at 2^32.
        lat         = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        tick();
        #1;
        check("wrap_req", {31'b0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr, 32'h0);
        tick();
        check_out("wrap_top", 32'hFFFF_FFFC);
        check("wrap_npc0", next_pc_out, 32'h0);
        tick();
        check_out("wrap_zero", 32'h0);

        // Memory not ready for 5 cycles.
        imem_ready = 1'b0;
        tick();
        check_out("gap_last", 32'd4);
        tick();
        tick();
        check_empty("gap");
        check("gap_pc_hold", pc_out, 32'd4);
        tick();
        tick();
`ifdef FETCH_STAT_EN
        check("gap_bubble", bubble_count, 32'd11);
`endif
        imem_ready = 1'b1;
        tick();
        check_empty("gap_end");
        tick();
        check_out("gap_resume", 32'd8);
`ifdef FETCH_STAT_EN
        check("end_bubble", bubble_count, 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
